// File: rtl/loop_ctl_pkg.sv
// Shared types and constants for the loop-telemetry receivers.
package loop_ctl_pkg;

    // Default counter/result width for duty measurements.
    localparam int unsigned CNT_W_DEFAULT = 10;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StHigh  = 2'd1,
        StLow   = 2'd2,
        StStuck = 2'd3
    } pwm_state_e;

    // One completed measurement at the default width, for downstream consumers.
    typedef struct packed {
        logic [CNT_W_DEFAULT-1:0] high;
        logic [CNT_W_DEFAULT-1:0] period;
    } meas_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level plus rising-edge detect.
// SYNC_STAGES must be at least 2.
module pwm_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pwm_s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_d_q;

    // Shift the async input through the chain; keep a one-cycle delayed copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            pwm_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
            pwm_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pwm_s = sync_q[SYNC_STAGES-1];
    assign rise  = pwm_s & ~pwm_d_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures high time and period of the PWM gate command in clock cycles and
// presents each completed period on a valid/ready interface.
module pwm_duty_decoder
    import loop_ctl_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             CELCLK,
    input  logic             CELRSTN,
    input  logic             CELV,
    input  logic             CELG,
    input  logic             SUB,
    input  logic             pwm_i,
    output logic             meas_valid_o,
    input  logic             meas_ready_i,
    output logic [CNT_W-1:0] high_o,
    output logic [CNT_W-1:0] period_o,
    output logic             overrun_o,
    output logic             stuck_o,
    output logic             stuck_lvl_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Power/substrate pins carry no logic.
    logic unused_pins;
    assign unused_pins = CELV ^ CELG ^ SUB;

    logic pwm_s;
    logic rise;

    pwm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (CELCLK),
        .rst_n(CELRSTN),
        .din  (pwm_i),
        .pwm_s(pwm_s),
        .rise (rise)
    );

    pwm_state_e       state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;

    // Capture pulse and data, one cycle ahead of the output register.
    logic             cap_q, cap_d;
    logic [CNT_W-1:0] cap_high_q, cap_high_d;
    logic [CNT_W-1:0] cap_period_q, cap_period_d;

    logic             valid_q, valid_d;
    logic [CNT_W-1:0] high_out_q, high_out_d;
    logic [CNT_W-1:0] period_out_q, period_out_d;
    logic             overrun_q, overrun_d;
    logic             accept;

    // Measurement FSM and counter state.
    always_ff @(posedge CELCLK) begin
        if (!CELRSTN) begin
            state_q      <= StIdle;
            period_q     <= '0;
            high_q       <= '0;
            cap_q        <= 1'b0;
            cap_high_q   <= '0;
            cap_period_q <= '0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            high_q       <= high_d;
            cap_q        <= cap_d;
            cap_high_q   <= cap_high_d;
            cap_period_q <= cap_period_d;
        end
    end

    // Next-state: count high/low cycles, capture on the closing rise, saturate to STUCK.
    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        high_d       = high_q;
        cap_d        = 1'b0;
        cap_high_d   = cap_high_q;
        cap_period_d = cap_period_q;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d  = StHigh;
                    period_d = CNT_ONE;
                    high_d   = CNT_ONE;
                end
            end
            StHigh: begin
                if (period_q == CNT_MAX) begin
                    state_d = StStuck;
                end else if (pwm_s) begin
                    period_d = period_q + CNT_ONE;
                    high_d   = high_q + CNT_ONE;
                end else begin
                    period_d = period_q + CNT_ONE;
                    state_d  = StLow;
                end
            end
            StLow: begin
                // A rise closes the period even when the counter sits at its maximum.
                if (rise) begin
                    cap_d        = 1'b1;
                    cap_high_d   = high_q;
                    cap_period_d = period_q;
                    period_d     = CNT_ONE;
                    high_d       = CNT_ONE;
                    state_d      = StHigh;
                end else if (period_q == CNT_MAX) begin
                    state_d = StStuck;
                end else begin
                    period_d = period_q + CNT_ONE;
                end
            end
            StStuck: begin
                // Partial period is discarded; counting restarts on the next rise.
                if (rise) begin
                    period_d = CNT_ONE;
                    high_d   = CNT_ONE;
                    state_d  = StHigh;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign accept = valid_q & meas_ready_i;

    // Output holding register and sticky overrun.
    always_ff @(posedge CELCLK) begin
        if (!CELRSTN) begin
            valid_q      <= 1'b0;
            high_out_q   <= '0;
            period_out_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            high_out_q   <= high_out_d;
            period_out_q <= period_out_d;
            overrun_q    <= overrun_d;
        end
    end

    // Load on capture when the slot is free or being emptied; otherwise drop and flag.
    always_comb begin
        valid_d      = valid_q;
        high_out_d   = high_out_q;
        period_out_d = period_out_q;
        overrun_d    = overrun_q;
        if (accept) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (cap_q) begin
            if (!valid_q || accept) begin
                valid_d      = 1'b1;
                high_out_d   = cap_high_q;
                period_out_d = cap_period_q;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign meas_valid_o = valid_q;
    assign high_o       = high_out_q;
    assign period_o     = period_out_q;
    assign overrun_o    = overrun_q;
    assign stuck_o      = (state_q == StStuck);
    assign stuck_lvl_o  = stuck_o & pwm_s;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder with hand-computed expectations.
module tb_pwm_duty_decoder;

    localparam int unsigned CNT_W = 10;

    logic             CELCLK = 1'b0;
    logic             CELRSTN = 1'b0;
    logic             pwm_i = 1'b0;
    logic             meas_ready_i = 1'b0;
    logic             meas_valid_o;
    logic [CNT_W-1:0] high_o;
    logic [CNT_W-1:0] period_o;
    logic             overrun_o;
    logic             stuck_o;
    logic             stuck_lvl_o;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int xfers    = 0;
    int last_high   = 0;
    int last_period = 0;
    int last_xfer   = -1;
    int last_gap    = 0;

    pwm_duty_decoder #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2)
    ) dut (
        .CELCLK      (CELCLK),
        .CELRSTN     (CELRSTN),
        .CELV        (1'b1),
        .CELG        (1'b0),
        .SUB         (1'b0),
        .pwm_i       (pwm_i),
        .meas_valid_o(meas_valid_o),
        .meas_ready_i(meas_ready_i),
        .high_o      (high_o),
        .period_o    (period_o),
        .overrun_o   (overrun_o),
        .stuck_o     (stuck_o),
        .stuck_lvl_o (stuck_lvl_o)
    );

    always #5 CELCLK = ~CELCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Hold pwm_i at v for n sampling edges; log every accepted transfer.
    task automatic drive(input logic v, input int n);
        pwm_i = v;
        repeat (n) begin
            @(posedge CELCLK);
            #1;
            cyc++;
            if (meas_valid_o && meas_ready_i) begin
                xfers++;
                last_high   = int'(high_o);
                last_period = int'(period_o);
                if (last_xfer >= 0) last_gap = cyc - last_xfer;
                last_xfer = cyc;
            end
        end
    endtask

    task automatic do_reset();
        CELRSTN = 1'b0;
        pwm_i   = 1'b0;
        repeat (2) @(posedge CELCLK);
        #1;
        CELRSTN   = 1'b1;
        xfers     = 0;
        last_xfer = -1;
        last_gap  = 0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check_eq("rst_valid", 32'(meas_valid_o), 0);
        check_eq("rst_high", 32'(high_o), 0);
        check_eq("rst_period", 32'(period_o), 0);
        check_eq("rst_overrun", 32'(overrun_o), 0);
        check_eq("rst_stuck", 32'(stuck_o), 0);

        // Steady 30/70 with ready held high
        meas_ready_i = 1'b1;
        drive(1'b0, 5);
        repeat (4) begin
            drive(1'b1, 30);
            drive(1'b0, 70);
        end
        check_eq("steady_xfers", 32'(xfers), 3);
        check_eq("steady_high", 32'(last_high), 30);
        check_eq("steady_period", 32'(last_period), 100);
        check_eq("steady_gap", 32'(last_gap), 100);

        // Backpressure across two periods of 10/10
        do_reset();
        meas_ready_i = 1'b0;
        drive(1'b0, 3);
        repeat (3) begin
            drive(1'b1, 10);
            drive(1'b0, 10);
        end
        check_eq("bp_valid", 32'(meas_valid_o), 1);
        check_eq("bp_high", 32'(high_o), 10);
        check_eq("bp_period", 32'(period_o), 20);
        check_eq("bp_overrun", 32'(overrun_o), 1);
        meas_ready_i = 1'b1;
        @(posedge CELCLK);
        #1;
        check_eq("bp_valid_drop", 32'(meas_valid_o), 0);
        check_eq("bp_overrun_clr", 32'(overrun_o), 0);

        // Stuck high, recovery, then a clean period
        do_reset();
        meas_ready_i = 1'b1;
        drive(1'b0, 3);
        drive(1'b1, 1000);
        check_eq("stuck_early", 32'(stuck_o), 0);
        drive(1'b1, 100);
        check_eq("stuck_set", 32'(stuck_o), 1);
        check_eq("stuck_lvl_hi", 32'(stuck_lvl_o), 1);
        drive(1'b0, 20);
        check_eq("stuck_hold", 32'(stuck_o), 1);
        check_eq("stuck_lvl_lo", 32'(stuck_lvl_o), 0);
        drive(1'b1, 20);
        check_eq("stuck_clear", 32'(stuck_o), 0);
        drive(1'b0, 30);
        check_eq("stuck_no_meas", 32'(xfers), 0);
        drive(1'b1, 5);
        drive(1'b0, 5);
        check_eq("stuck_rec_xfers", 32'(xfers), 1);
        check_eq("stuck_rec_high", 32'(last_high), 20);
        check_eq("stuck_rec_period", 32'(last_period), 50);

        // Narrowest pulse train 1/1
        do_reset();
        meas_ready_i = 1'b1;
        drive(1'b0, 3);
        repeat (6) begin
            drive(1'b1, 1);
            drive(1'b0, 1);
        end
        drive(1'b0, 5);
        check_eq("narrow_xfers", 32'(xfers), 5);
        check_eq("narrow_high", 32'(last_high), 1);
        check_eq("narrow_period", 32'(last_period), 2);

        // Capture coincident with acceptance
        do_reset();
        meas_ready_i = 1'b0;
        drive(1'b0, 3);
        drive(1'b1, 5);
        drive(1'b0, 7);
        drive(1'b1, 8);
        drive(1'b0, 6);
        check_eq("coin_old_high", 32'(high_o), 5);
        check_eq("coin_old_period", 32'(period_o), 12);
        pwm_i = 1'b1;
        repeat (3) begin
            @(posedge CELCLK);
            #1;
        end
        meas_ready_i = 1'b1;
        @(posedge CELCLK);
        #1;
        check_eq("coin_valid", 32'(meas_valid_o), 1);
        check_eq("coin_high", 32'(high_o), 8);
        check_eq("coin_period", 32'(period_o), 14);
        check_eq("coin_overrun", 32'(overrun_o), 0);
        @(posedge CELCLK);
        #1;
        check_eq("coin_drop", 32'(meas_valid_o), 0);

        // Reset in the middle of a high phase with a measurement pending
        do_reset();
        meas_ready_i = 1'b0;
        drive(1'b0, 3);
        drive(1'b1, 10);
        drive(1'b0, 10);
        drive(1'b1, 5);
        check_eq("mid_pre_valid", 32'(meas_valid_o), 1);
        CELRSTN = 1'b0;
        pwm_i   = 1'b0;
        @(posedge CELCLK);
        #1;
        check_eq("mid_valid", 32'(meas_valid_o), 0);
        check_eq("mid_high", 32'(high_o), 0);
        check_eq("mid_period", 32'(period_o), 0);
        check_eq("mid_overrun", 32'(overrun_o), 0);
        check_eq("mid_stuck", 32'(stuck_o), 0);
        CELRSTN      = 1'b1;
        meas_ready_i = 1'b1;
        xfers        = 0;
        drive(1'b0, 5);
        drive(1'b1, 15);
        drive(1'b0, 25);
        check_eq("mid_first_rise", 32'(xfers), 0);
        drive(1'b1, 5);
        drive(1'b0, 5);
        check_eq("mid_xfers", 32'(xfers), 1);
        check_eq("mid_new_high", 32'(last_high), 15);
        check_eq("mid_new_period", 32'(last_period), 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
